// File: rtl/sat_adj_ctrl.sv
// Frame-synchronous adjust-value controller: snoops the video stream and commits
// new saturation settings in the blanking gap after a frame, optionally ramping.
module sat_adj_ctrl #(
  parameter int                V_LINES     = 1080,
  parameter int                DRAIN_CYC   = 2,
  parameter int                RAMP_STEP   = 8,
  parameter logic signed [8:0] DEFAULT_VAL = 9'sd128
) (
  input  logic               I_clk,
  input  logic               I_rst,
  input  logic               I_cfg_we,
  input  logic signed [8:0]  I_cfg_val,
  input  logic               I_cfg_ramp,
  input  logic               I_cfg_bypass,
  input  logic               I_err_clr,
  input  logic               I_tvalid,
  input  logic               I_tuser,
  input  logic               I_tlast,
  output logic signed [8:0]  O_adjust_val,
  output logic               O_bypass,
  output logic               O_busy,
  output logic [15:0]        O_frame_cnt,
  output logic               O_sync_err,
  output logic               O_gap_err
);

  localparam int                 LW         = (V_LINES > 1) ? $clog2(V_LINES) : 1;
  localparam logic [LW-1:0]      LAST_LINE  = LW'(V_LINES - 1);
  localparam int                 DW         = $clog2(DRAIN_CYC) + 1;
  localparam logic [DW-1:0]      DRAIN_LAST = DW'(DRAIN_CYC - 1);
  localparam logic signed [9:0]  STEP10     = 10'(RAMP_STEP);

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN, COMMIT} state_t;

  state_t            state, state_nxt;
  logic [LW-1:0]     line_cnt, line_eff;
  logic [DW-1:0]     drain_cnt;
  logic              in_frame;
  logic signed [8:0] target;
  logic              ramp_mode;
  logic              pend_bypass;
  logic signed [8:0] commit_val;
  logic              sof, line_end, eof, sync_evt, gap_evt;

  // The datapath's magnitude path cannot represent -256.
  function automatic logic signed [8:0] sat_cfg(input logic signed [8:0] v);
    return (v == 9'sh100) ? -9'sd255 : v;
  endfunction

  function automatic logic signed [8:0] ramp_next(input logic signed [8:0] act,
                                                  input logic signed [8:0] tgt,
                                                  input logic              ramp);
    logic signed [9:0] diff, mag, sum;
    diff = $signed({tgt[8], tgt}) - $signed({act[8], act});
    mag  = diff[9] ? -diff : diff;
    if (!ramp || mag <= STEP10) return tgt;
    sum = $signed({act[8], act}) + (diff[9] ? -STEP10 : STEP10);
    if (sum > 10'sd255)       sum = 10'sd255;
    else if (sum < -10'sd255) sum = -10'sd255;
    return sum[8:0];
  endfunction

  always_comb begin
    sof        = I_tvalid & I_tuser;
    line_end   = I_tvalid & I_tlast;
    line_eff   = sof ? '0 : line_cnt;
    eof        = line_end & (line_eff == LAST_LINE);
    sync_evt   = sof & (line_cnt != '0);
    commit_val = ramp_next(O_adjust_val, target, ramp_mode);
  end

  // A write on the SOF beat counts as in-frame so it never skips the drain.
  always_comb begin
    state_nxt = state;
    gap_evt   = 1'b0;
    case (state)
      IDLE:   if (I_cfg_we) state_nxt = (in_frame | sof) ? WAIT : COMMIT;
      WAIT:   if (eof) state_nxt = DRAIN;
      DRAIN: begin
        if (sof) begin
          state_nxt = COMMIT;
          gap_evt   = 1'b1;
        end else if (drain_cnt == DRAIN_LAST) begin
          state_nxt = COMMIT;
        end
      end
      COMMIT: state_nxt = (I_cfg_we || commit_val != target) ? WAIT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state        <= IDLE;
      line_cnt     <= '0;
      drain_cnt    <= '0;
      in_frame     <= 1'b0;
      target       <= DEFAULT_VAL;
      ramp_mode    <= 1'b0;
      pend_bypass  <= 1'b0;
      O_adjust_val <= DEFAULT_VAL;
      O_bypass     <= 1'b0;
      O_busy       <= 1'b0;
      O_frame_cnt  <= '0;
      O_sync_err   <= 1'b0;
      O_gap_err    <= 1'b0;
    end else begin
      state  <= state_nxt;
      O_busy <= (state_nxt != IDLE);

      if (I_cfg_we) begin
        target      <= sat_cfg(I_cfg_val);
        ramp_mode   <= I_cfg_ramp;
        pend_bypass <= I_cfg_bypass;
      end

      if (line_end) line_cnt <= eof ? '0 : line_eff + 1'b1;
      else          line_cnt <= line_eff;

      if (eof)      in_frame <= 1'b0;
      else if (sof) in_frame <= 1'b1;

      if (eof) O_frame_cnt <= O_frame_cnt + 16'd1;

      drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;

      // Commit stage: target/bypass are the values registered before this cycle.
      if (state == COMMIT) begin
        O_adjust_val <= commit_val;
        O_bypass     <= pend_bypass;
      end

      O_sync_err <= sync_evt | (O_sync_err & ~I_err_clr);
      O_gap_err  <= gap_evt  | (O_gap_err  & ~I_err_clr);
    end
  end

endmodule

// File: tb/tb_sat_adj_ctrl.sv
// Directed bench for sat_adj_ctrl with V_LINES=4, DRAIN_CYC=2, RAMP_STEP=8.
module tb_sat_adj_ctrl;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cfg_we = 1'b0;
  logic signed [8:0] cfg_val = '0;
  logic              cfg_ramp = 1'b0;
  logic              cfg_bypass = 1'b0;
  logic              err_clr = 1'b0;
  logic              tvalid = 1'b0;
  logic              tuser = 1'b0;
  logic              tlast = 1'b0;
  logic signed [8:0] adjust_val;
  logic              bypass;
  logic              busy;
  logic [15:0]       frame_cnt;
  logic              sync_err;
  logic              gap_err;

  int n_cmp  = 0;
  int n_fail = 0;

  sat_adj_ctrl #(
    .V_LINES(4), .DRAIN_CYC(2), .RAMP_STEP(8), .DEFAULT_VAL(9'sd128)
  ) dut (
    .I_clk(clk), .I_rst(rst), .I_cfg_we(cfg_we), .I_cfg_val(cfg_val),
    .I_cfg_ramp(cfg_ramp), .I_cfg_bypass(cfg_bypass), .I_err_clr(err_clr),
    .I_tvalid(tvalid), .I_tuser(tuser), .I_tlast(tlast),
    .O_adjust_val(adjust_val), .O_bypass(bypass), .O_busy(busy),
    .O_frame_cnt(frame_cnt), .O_sync_err(sync_err), .O_gap_err(gap_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic u, input logic l);
    tvalid = 1'b1; tuser = u; tlast = l;
    tick();
    tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0;
  endtask

  task automatic write(input logic signed [8:0] v, input logic r, input logic b);
    cfg_we = 1'b1; cfg_val = v; cfg_ramp = r; cfg_bypass = b;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic lines3_then_drain();
    beat(1'b0, 1'b1);
    beat(1'b0, 1'b1);
    beat(1'b0, 1'b1);
    tick(); tick(); tick();
  endtask

  initial begin
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_adjust", adjust_val, 128);
    chk("rst_bypass", bypass, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_sync_err", sync_err, 0);
    chk("rst_gap_err", gap_err, 0);

    // Idle write before any SOF
    write(9'sd200, 1'b0, 1'b0);
    chk("idle_hold", adjust_val, 128);
    chk("idle_busy_on", busy, 1);
    tick();
    chk("idle_commit", adjust_val, 200);
    chk("idle_busy_off", busy, 0);

    // Frame-aligned commit
    beat(1'b1, 1'b1);
    write(-9'sd100, 1'b0, 1'b1);
    beat(1'b0, 1'b1);
    beat(1'b0, 1'b1);
    chk("frm_busy_wait", busy, 1);
    beat(1'b0, 1'b1);
    chk("frm_eof_cnt", frame_cnt, 1);
    chk("frm_eof_hold", adjust_val, 200);
    tick();
    chk("frm_eof1_hold", adjust_val, 200);
    tick();
    chk("frm_eof2_hold", adjust_val, 200);
    tick();
    chk("frm_eof3_val", adjust_val, -100);
    chk("frm_eof3_bypass", bypass, 1);
    chk("frm_eof3_busy", busy, 0);

    // Ramp 0 -> 20 in steps of 8
    write(9'sd0, 1'b0, 1'b0);
    tick();
    chk("ramp_start", adjust_val, 0);
    chk("ramp_start_byp", bypass, 0);
    beat(1'b1, 1'b1);
    write(9'sd20, 1'b1, 1'b0);
    lines3_then_drain();
    chk("ramp_step1", adjust_val, 8);
    chk("ramp_busy1", busy, 1);
    beat(1'b1, 1'b1);
    lines3_then_drain();
    chk("ramp_step2", adjust_val, 16);
    chk("ramp_busy2", busy, 1);
    beat(1'b1, 1'b1);
    lines3_then_drain();
    chk("ramp_step3", adjust_val, 20);
    chk("ramp_busy3", busy, 0);
    chk("ramp_frames", frame_cnt, 4);

    // Saturation and last-write-wins
    beat(1'b1, 1'b1);
    write(-9'sd256, 1'b0, 1'b0);
    write(9'sd50, 1'b0, 1'b0);
    lines3_then_drain();
    chk("last_wins", adjust_val, 50);
    beat(1'b1, 1'b1);
    write(-9'sd256, 1'b0, 1'b0);
    lines3_then_drain();
    chk("sat_m256", adjust_val, -255);

    // SOF one cycle after EOF while draining
    beat(1'b1, 1'b1);
    write(9'sd77, 1'b0, 1'b0);
    beat(1'b0, 1'b1);
    beat(1'b0, 1'b1);
    beat(1'b0, 1'b1);
    beat(1'b1, 1'b0);
    chk("gap_err_set", gap_err, 1);
    chk("gap_hold", adjust_val, -255);
    tick();
    chk("gap_commit", adjust_val, 77);
    chk("gap_no_sync", sync_err, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("gap_err_clr", gap_err, 0);

    // SOF after 2 of 4 lines
    beat(1'b0, 1'b1);
    beat(1'b0, 1'b1);
    beat(1'b1, 1'b0);
    chk("sync_err_set", sync_err, 1);
    beat(1'b0, 1'b1);
    beat(1'b0, 1'b1);
    beat(1'b0, 1'b1);
    chk("sync_restart_cnt", frame_cnt, 7);
    beat(1'b0, 1'b1);
    chk("sync_restart_eof", frame_cnt, 8);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("sync_err_clr", sync_err, 0);

    // Reset during DRAIN drops the pending change
    beat(1'b1, 1'b1);
    write(-9'sd30, 1'b0, 1'b1);
    beat(1'b0, 1'b1);
    beat(1'b0, 1'b1);
    beat(1'b0, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstdrain_val", adjust_val, 128);
    chk("rstdrain_busy", busy, 0);
    chk("rstdrain_frames", frame_cnt, 0);
    tick(); tick(); tick();
    chk("rstdrain_lost", adjust_val, 128);
    chk("rstdrain_byp", bypass, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
